// File: rtl/mips_bus_access_unit.sv
// Bus access unit: arbitrates fetch and data channels onto one Avalon-style bus.
// Define BUS_ENDIAN_SWAP_EN for a big-endian core (byte-swapped lane mapping).
module mips_bus_access_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          DATA_PRIORITY  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  input  logic [31:0]           d_wdata,
  output logic                  d_ready,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  output logic                  write,
  output logic [3:0]            byteenable,
  output logic [31:0]           writedata,
  input  logic                  waitrequest,
  input  logic [31:0]           readdata,
  output logic                  busy,
  output logic                  timeout_err
);

`ifdef BUS_ENDIAN_SWAP_EN
  localparam bit SwapEn = 1'b1;
`else
  localparam bit SwapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e                state_q;
  logic                  is_data_q;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [31:0]           wait_cnt_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic                  read_q, write_q;
  logic [3:0]            byteenable_q;
  logic [31:0]           writedata_q;
  logic                  if_ready_q, d_ready_q, d_err_q, timeout_err_q;
  logic [31:0]           if_rdata_q, d_rdata_q;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  logic        sel_data, misaligned, tmo_hit;
  logic [3:0]  st_be;
  logic [31:0] st_data, word_core, ld_val;
  logic [15:0] st_half, half_raw, half_v;
  logic [7:0]  lane_b;

  assign sel_data   = d_req && (DATA_PRIORITY || !if_req);
  assign misaligned = (d_size == 2'd3) || (d_size == 2'd1 && d_addr[0]) ||
                      (d_size == 2'd2 && d_addr[1:0] != 2'b00);
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && waitrequest &&
                      (wait_cnt_q + 32'd1 == TIMEOUT_CYCLES);
  assign st_half    = SwapEn ? {d_wdata[7:0], d_wdata[15:8]} : d_wdata[15:0];
  assign word_core  = SwapEn ? bswap(readdata) : readdata;

  // Store lanes: sub-word data replicated so every candidate lane carries it.
  always_comb begin
    st_be   = 4'b1111;
    st_data = SwapEn ? bswap(d_wdata) : d_wdata;
    case (d_size)
      2'd0: begin
        st_be   = 4'b0001 << d_addr[1:0];
        st_data = {4{d_wdata[7:0]}};
      end
      2'd1: begin
        st_be   = 4'b0011 << d_addr[1:0];
        st_data = {2{st_half}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b   = readdata[{off_q, 3'b000} +: 8];
    half_raw = readdata[{off_q[1], 4'b0000} +: 16];
    half_v   = SwapEn ? {half_raw[7:0], half_raw[15:8]} : half_raw;
    case (size_q)
      2'd0:    ld_val = {{24{sign_q & lane_b[7]}}, lane_b};
      2'd1:    ld_val = {{16{sign_q & half_v[15]}}, half_v};
      default: ld_val = word_core;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      is_data_q     <= 1'b0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      sign_q        <= 1'b0;
      wait_cnt_q    <= '0;
      address_q     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      byteenable_q  <= 4'b0000;
      writedata_q   <= '0;
      if_ready_q    <= 1'b0;
      d_ready_q     <= 1'b0;
      d_err_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sel_data) begin
            is_data_q <= 1'b1;
            off_q     <= d_addr[1:0];
            size_q    <= d_size;
            sign_q    <= d_signed;
            if (misaligned) begin
              state_q   <= StResp;
              d_ready_q <= 1'b1;
              d_err_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              state_q      <= StBus;
              wait_cnt_q   <= '0;
              address_q    <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
              read_q       <= !d_we;
              write_q      <= d_we;
              byteenable_q <= d_we ? st_be : 4'b1111;
              writedata_q  <= d_we ? st_data : 32'd0;
            end
          end else if (if_req) begin
            is_data_q    <= 1'b0;
            state_q      <= StBus;
            wait_cnt_q   <= '0;
            address_q    <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
            read_q       <= 1'b1;
            write_q      <= 1'b0;
            byteenable_q <= 4'b1111;
          end
        end
        StBus: begin
          if (!waitrequest || tmo_hit) begin
            state_q      <= StResp;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= 4'b0000;
            if (tmo_hit) timeout_err_q <= 1'b1;
            if (is_data_q) begin
              d_ready_q <= 1'b1;
              d_err_q   <= tmo_hit;
              d_rdata_q <= (tmo_hit || write_q) ? 32'd0 : ld_val;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= tmo_hit ? 32'd0 : word_core;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          if_ready_q <= 1'b0;
          d_ready_q  <= 1'b0;
          d_err_q    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_ready    = if_ready_q;
  assign if_rdata    = if_rdata_q;
  assign d_ready     = d_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign address     = address_q;
  assign read        = read_q;
  assign write       = write_q;
  assign byteenable  = byteenable_q;
  assign writedata   = writedata_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule
